// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/decode/execute control unit for the 4-bit-address,
// 8-bit-data CPU datapath (PC, MAR, RAM, IR, A/B registers, ALU).
//
// A Moore state machine walks each instruction through fetch, decode and
// execute. It waits on the RAM ready handshake in both read states and
// holds MUL/DIV for MULDIV_CYCLES cycles. Every strobe is a registered decode
// of the state being entered, so it lines up with the registered state and
// has no glitches. Reset is asynchronous and active-low, so the strobes drop
// as soon as reset goes low.
//
// Optional build macro:
//   CPUF_SINGLE_STEP_EN - adds step_mode/step inputs and the PAUSE state.
//                         Completions park in PAUSE while step_mode=1.
//
// Ports:
//   clk, reset           rising-edge clock, async active-low reset
//   run                  level, leaves IDLE while high (ignored elsewhere)
//   ir_op[3:0]           opcode field from the instruction register
//   ram_ready            RAM read data valid (only looked at in F_RD/EX_RD)
//   step_mode, step      single-step controls (CPUF_SINGLE_STEP_EN only)
//   pc_out .. b_load     one-hot datapath control strobes
//   halted               in HALT
//   illegal_op           sticky, undefined opcode decoded
//   mem_timeout          sticky, ram_ready wait exceeded WAIT_MAX
//   instr_count[7:0]     retired instructions, wraps
//   state[3:0]           current state encoding (debug)

module micro_sequencer #(
    parameter int unsigned WAIT_MAX      = 15,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] ir_op,
    input  logic       ram_ready,
`ifdef CPUF_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_rd_i,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ram_rd_a,
    output logic       ram_rd_b,
    output logic       a_out,
    output logic       alu_add,
    output logic       alu_sub,
    output logic       alu_mul,
    output logic       alu_div,
    output logic       b_load,
    output logic       halted,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [7:0] instr_count,
    output logic [3:0] state
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned MD_W   = 4;
    localparam int unsigned STRB_W = 14;

    // Bit positions of the strobe vector
    localparam int unsigned SB_PC_OUT   = 13;
    localparam int unsigned SB_MAR_LOAD = 12;
    localparam int unsigned SB_RAM_RD_I = 11;
    localparam int unsigned SB_IR_LOAD  = 10;
    localparam int unsigned SB_PC_INC   = 9;
    localparam int unsigned SB_PC_LOAD  = 8;
    localparam int unsigned SB_RAM_RD_A = 7;
    localparam int unsigned SB_RAM_RD_B = 6;
    localparam int unsigned SB_A_OUT    = 5;
    localparam int unsigned SB_ALU_ADD  = 4;
    localparam int unsigned SB_ALU_SUB  = 3;
    localparam int unsigned SB_ALU_MUL  = 2;
    localparam int unsigned SB_ALU_DIV  = 1;
    localparam int unsigned SB_B_LOAD   = 0;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_LDB = 4'b0100;
    localparam logic [OP_W-1:0] OP_LDA = 4'b1000;
    localparam logic [OP_W-1:0] OP_JMP = 4'b1001;
    localparam logic [OP_W-1:0] OP_DIV = 4'b1010;
    localparam logic [OP_W-1:0] OP_MUL = 4'b1100;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);
    localparam logic [MD_W-1:0]  MD_LAST    = MD_W'(MULDIV_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_RD   = 4'd2,
        S_F_IR   = 4'd3,
        S_DECODE = 4'd4,
        S_EX_RD  = 4'd5,
        S_EX_ALU = 4'd6,
        S_EX_MD  = 4'd7,
        S_EX_JMP = 4'd8,
        S_HALT   = 4'd9
`ifdef CPUF_SINGLE_STEP_EN
        , S_PAUSE = 4'd10
`endif
    } state_t;

    state_t              state_q, state_n;
    state_t              done_tgt;
    logic [OP_W-1:0]     op_q, op_n;
    logic [CNT_W-1:0]    wait_q, wait_n, wait_inc;
    logic [MD_W-1:0]     md_q, md_n;
    logic [CNT_W-1:0]    count_n;
    logic                illegal_n, timeout_n, halted_n;
    logic                retire;
    logic [STRB_W-1:0]   strb_q, strb_n;

    // Where a finished instruction goes next
`ifdef CPUF_SINGLE_STEP_EN
    assign done_tgt = step_mode ? S_PAUSE : S_F_ADDR;
`else
    assign done_tgt = S_F_ADDR;
`endif

    assign wait_inc = wait_q + CNT_W'(1);

    // Next-state, counters, sticky flags and strobe decode of the next state
    always_comb begin
        state_n   = state_q;
        op_n      = op_q;
        wait_n    = wait_q;
        md_n      = md_q;
        illegal_n = illegal_op;
        timeout_n = mem_timeout;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_n = S_F_ADDR;
                end
            end
            S_F_ADDR: begin
                state_n = S_F_RD;
                wait_n  = '0;
            end
            S_F_RD: begin
                // ram_ready wins over a timeout that would land on the same cycle
                if (ram_ready) begin
                    state_n = S_F_IR;
                end else begin
                    wait_n = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = S_HALT;
                    end
                end
            end
            S_F_IR: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                op_n = ir_op;
                case (ir_op)
                    OP_LDA, OP_LDB: begin
                        state_n = S_EX_RD;
                        wait_n  = '0;
                    end
                    OP_ADD, OP_SUB: state_n = S_EX_ALU;
                    OP_MUL, OP_DIV: begin
                        state_n = S_EX_MD;
                        md_n    = '0;
                    end
                    OP_JMP: state_n = S_EX_JMP;
                    OP_HLT: state_n = S_HALT;
                    OP_NOP: begin
                        state_n = done_tgt;
                        retire  = 1'b1;
                    end
                    default: begin
                        illegal_n = 1'b1;
                        state_n   = S_HALT;
                    end
                endcase
            end
            S_EX_RD: begin
                if (ram_ready) begin
                    state_n = done_tgt;
                    retire  = 1'b1;
                end else begin
                    wait_n = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = S_HALT;
                    end
                end
            end
            S_EX_ALU, S_EX_JMP: begin
                state_n = done_tgt;
                retire  = 1'b1;
            end
            S_EX_MD: begin
                if (md_q == MD_LAST) begin
                    state_n = done_tgt;
                    retire  = 1'b1;
                end else begin
                    md_n = md_q + MD_W'(1);
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
`ifdef CPUF_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step || !step_mode) begin
                    state_n = S_F_ADDR;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase

        count_n = retire ? (instr_count + CNT_W'(1)) : instr_count;

        // Strobes are a decode of the state being entered, registered below
        strb_n                = '0;
        strb_n[SB_PC_OUT]     = (state_n == S_F_ADDR);
        strb_n[SB_MAR_LOAD]   = (state_n == S_F_ADDR);
        strb_n[SB_RAM_RD_I]   = (state_n == S_F_RD);
        strb_n[SB_IR_LOAD]    = (state_n == S_F_IR);
        strb_n[SB_PC_INC]     = (state_n == S_F_IR);
        strb_n[SB_PC_LOAD]    = (state_n == S_EX_JMP);
        strb_n[SB_RAM_RD_A]   = (state_n == S_EX_RD) && (op_n == OP_LDA);
        strb_n[SB_RAM_RD_B]   = (state_n == S_EX_RD) && (op_n == OP_LDB);
        strb_n[SB_A_OUT]      = (state_n == S_EX_ALU) || (state_n == S_EX_MD);
        strb_n[SB_ALU_ADD]    = (state_n == S_EX_ALU) && (op_n == OP_ADD);
        strb_n[SB_ALU_SUB]    = (state_n == S_EX_ALU) && (op_n == OP_SUB);
        strb_n[SB_ALU_MUL]    = (state_n == S_EX_MD) && (op_n == OP_MUL);
        strb_n[SB_ALU_DIV]    = (state_n == S_EX_MD) && (op_n == OP_DIV);
        strb_n[SB_B_LOAD]     = (state_n == S_EX_ALU) ||
                                ((state_n == S_EX_MD) && (md_n == MD_LAST));
        halted_n              = (state_n == S_HALT);
    end

    // State, counters, flags and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wait_q      <= '0;
            md_q        <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            halted      <= 1'b0;
            strb_q      <= '0;
        end else begin
            state_q     <= state_n;
            op_q        <= op_n;
            wait_q      <= wait_n;
            md_q        <= md_n;
            instr_count <= count_n;
            illegal_op  <= illegal_n;
            mem_timeout <= timeout_n;
            halted      <= halted_n;
            strb_q      <= strb_n;
        end
    end

    assign pc_out   = strb_q[SB_PC_OUT];
    assign mar_load = strb_q[SB_MAR_LOAD];
    assign ram_rd_i = strb_q[SB_RAM_RD_I];
    assign ir_load  = strb_q[SB_IR_LOAD];
    assign pc_inc   = strb_q[SB_PC_INC];
    assign pc_load  = strb_q[SB_PC_LOAD];
    assign ram_rd_a = strb_q[SB_RAM_RD_A];
    assign ram_rd_b = strb_q[SB_RAM_RD_B];
    assign a_out    = strb_q[SB_A_OUT];
    assign alu_add  = strb_q[SB_ALU_ADD];
    assign alu_sub  = strb_q[SB_ALU_SUB];
    assign alu_mul  = strb_q[SB_ALU_MUL];
    assign alu_div  = strb_q[SB_ALU_DIV];
    assign b_load   = strb_q[SB_B_LOAD];
    assign state    = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed, table-driven bench for micro_sequencer (default parameters).
// Each vector gives the inputs applied for one clock and the state, strobes,
// count and flags expected right after that edge.

module tb_micro_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] ir_op;
    logic       ram_ready;
`ifdef CPUF_SINGLE_STEP_EN
    logic       step_mode;
    logic       step;
`endif
    logic       pc_out, mar_load, ram_rd_i, ir_load, pc_inc, pc_load;
    logic       ram_rd_a, ram_rd_b, a_out, alu_add, alu_sub, alu_mul, alu_div, b_load;
    logic       halted, illegal_op, mem_timeout;
    logic [7:0] instr_count;
    logic [3:0] state;

    micro_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .ir_op       (ir_op),
        .ram_ready   (ram_ready),
`ifdef CPUF_SINGLE_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .pc_out      (pc_out),
        .mar_load    (mar_load),
        .ram_rd_i    (ram_rd_i),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .ram_rd_a    (ram_rd_a),
        .ram_rd_b    (ram_rd_b),
        .a_out       (a_out),
        .alu_add     (alu_add),
        .alu_sub     (alu_sub),
        .alu_mul     (alu_mul),
        .alu_div     (alu_div),
        .b_load      (b_load),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .instr_count (instr_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_out, mar_load, ram_rd_i, ir_load, pc_inc, pc_load, ram_rd_a,
    //  ram_rd_b, a_out, alu_add, alu_sub, alu_mul, alu_div, b_load}
    logic [13:0] sb_act;
    assign sb_act = {pc_out, mar_load, ram_rd_i, ir_load, pc_inc, pc_load, ram_rd_a,
                     ram_rd_b, a_out, alu_add, alu_sub, alu_mul, alu_div, b_load};

    localparam logic [13:0] SB_NONE = 14'h0000;
    localparam logic [13:0] SB_FA   = 14'h3000;
    localparam logic [13:0] SB_FRD  = 14'h0800;
    localparam logic [13:0] SB_FIR  = 14'h0600;
    localparam logic [13:0] SB_JMP  = 14'h0100;
    localparam logic [13:0] SB_LDA  = 14'h0080;
    localparam logic [13:0] SB_LDB  = 14'h0040;
    localparam logic [13:0] SB_ADD  = 14'h0031;
    localparam logic [13:0] SB_SUB  = 14'h0029;
    localparam logic [13:0] SB_MUL  = 14'h0024;
    localparam logic [13:0] SB_MULB = 14'h0025;
    localparam logic [13:0] SB_DIV  = 14'h0022;
    localparam logic [13:0] SB_DIVB = 14'h0023;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_X   = 4'b0110;   // undefined; must be ignored outside DECODE

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic        rdy;
        logic        stp;
        logic [3:0]  st;
        logic [13:0] sb;
        logic [7:0]  cnt;
        logic [2:0]  flg;   // {halted, illegal_op, mem_timeout}
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] op, input logic rdy,
                                input logic [3:0] st, input logic [13:0] sb,
                                input logic [7:0] cnt, input logic [2:0] flg);
        vec_t v;
        v.run = r; v.op = op; v.rdy = rdy; v.stp = 1'b0;
        v.st = st; v.sb = sb; v.cnt = cnt; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // F_ADDR -> F_RD -> F_IR -> DECODE with ram_ready high
    task automatic push_fetch(input logic [7:0] cnt);
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd2, SB_FRD, cnt, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd3, SB_FIR, cnt, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd4, SB_NONE, cnt, 3'b000));
    endtask

    task automatic apply(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            run       = vq[i].run;
            ir_op     = vq[i].op;
            ram_ready = vq[i].rdy;
`ifdef CPUF_SINGLE_STEP_EN
            step      = vq[i].stp;
`endif
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] state", tag, i), 32'(state), 32'(vq[i].st));
            chk($sformatf("%s[%0d] strobes", tag, i), 32'(sb_act), 32'(vq[i].sb));
            chk($sformatf("%s[%0d] instr_count", tag, i), 32'(instr_count), 32'(vq[i].cnt));
            chk($sformatf("%s[%0d] flags", tag, i),
                32'({halted, illegal_op, mem_timeout}), 32'(vq[i].flg));
        end
        vq.delete();
    endtask

    // Assert reset between clock edges and confirm everything clears without a clock
    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        #2;
        chk({tag, " async state"}, 32'(state), 32'd0);
        chk({tag, " async strobes"}, 32'(sb_act), 32'd0);
        chk({tag, " async instr_count"}, 32'(instr_count), 32'd0);
        chk({tag, " async flags"}, 32'({halted, illegal_op, mem_timeout}), 32'd0);
        run       = 1'b0;
        ram_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        ir_op     = OP_NOP;
        ram_ready = 1'b0;
`ifdef CPUF_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset strobes", 32'(sb_act), 32'd0);
        chk("reset instr_count", 32'(instr_count), 32'd0);
        chk("reset flags", 32'({halted, illegal_op, mem_timeout}), 32'd0);
        reset = 1'b1;

        // Program: ADD, LDA (3 wait cycles), MUL, LDB, SUB, DIV, JMP, NOP, HLT
        vq.push_back(mk(1'b1, OP_X, 1'b1, 4'd1, SB_FA, 8'd0, 3'b000));
        push_fetch(8'd0);
        vq.push_back(mk(1'b0, OP_ADD, 1'b1, 4'd6, SB_ADD, 8'd0, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd1, 3'b000));
        push_fetch(8'd1);
        vq.push_back(mk(1'b0, OP_LDA, 1'b0, 4'd5, SB_LDA, 8'd1, 3'b000));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd5, SB_LDA, 8'd1, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd2, 3'b000));
        push_fetch(8'd2);
        vq.push_back(mk(1'b0, OP_MUL, 1'b0, 4'd7, SB_MUL, 8'd2, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd7, SB_MUL, 8'd2, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd7, SB_MUL, 8'd2, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd7, SB_MULB, 8'd2, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd1, SB_FA, 8'd3, 3'b000));
        push_fetch(8'd3);
        vq.push_back(mk(1'b0, OP_LDB, 1'b1, 4'd5, SB_LDB, 8'd3, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd4, 3'b000));
        push_fetch(8'd4);
        vq.push_back(mk(1'b0, OP_SUB, 1'b1, 4'd6, SB_SUB, 8'd4, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd5, 3'b000));
        push_fetch(8'd5);
        vq.push_back(mk(1'b0, OP_DIV, 1'b1, 4'd7, SB_DIV, 8'd5, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd7, SB_DIV, 8'd5, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd7, SB_DIV, 8'd5, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd7, SB_DIVB, 8'd5, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd6, 3'b000));
        push_fetch(8'd6);
        vq.push_back(mk(1'b0, OP_JMP, 1'b1, 4'd8, SB_JMP, 8'd6, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd7, 3'b000));
        push_fetch(8'd7);
        vq.push_back(mk(1'b0, OP_NOP, 1'b1, 4'd1, SB_FA, 8'd8, 3'b000));
        push_fetch(8'd8);
        vq.push_back(mk(1'b0, OP_HLT, 1'b1, 4'd9, SB_NONE, 8'd8, 3'b100));
        vq.push_back(mk(1'b1, OP_ADD, 1'b1, 4'd9, SB_NONE, 8'd8, 3'b100));
        vq.push_back(mk(1'b0, OP_NOP, 1'b1, 4'd9, SB_NONE, 8'd8, 3'b100));
        apply("prog");
        async_reset_check("prog");

        // Undefined opcode: sticky illegal_op, HALT, run has no effect
        vq.push_back(mk(1'b1, OP_X, 1'b1, 4'd1, SB_FA, 8'd0, 3'b000));
        push_fetch(8'd0);
        vq.push_back(mk(1'b0, 4'b0110, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b110));
        vq.push_back(mk(1'b1, OP_NOP, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b110));
        vq.push_back(mk(1'b0, OP_NOP, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b110));
        vq.push_back(mk(1'b1, OP_NOP, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b110));
        apply("illegal");
        async_reset_check("illegal");

        // ram_ready never arrives: 15 cycles in F_RD then HALT with mem_timeout
        vq.push_back(mk(1'b1, OP_X, 1'b0, 4'd1, SB_FA, 8'd0, 3'b000));
        for (int k = 0; k < 15; k++)
            vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd2, SB_FRD, 8'd0, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd9, SB_NONE, 8'd0, 3'b101));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b101));
        vq.push_back(mk(1'b1, OP_X, 1'b1, 4'd9, SB_NONE, 8'd0, 3'b101));
        apply("timeout");
        async_reset_check("timeout");

        // ram_ready on the last allowed wait cycle: no timeout
        vq.push_back(mk(1'b1, OP_X, 1'b0, 4'd1, SB_FA, 8'd0, 3'b000));
        for (int k = 0; k < 15; k++)
            vq.push_back(mk(1'b0, OP_X, 1'b0, 4'd2, SB_FRD, 8'd0, 3'b000));
        vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd3, SB_FIR, 8'd0, 3'b000));
        apply("edge");
        // Abort mid-instruction while ir_load/pc_inc are high
        async_reset_check("abort");

`ifdef CPUF_SINGLE_STEP_EN
        // Single step: NOP parks in PAUSE until a step pulse
        begin
            vec_t v;
            step_mode = 1'b1;
            vq.push_back(mk(1'b1, OP_X, 1'b1, 4'd1, SB_FA, 8'd0, 3'b000));
            push_fetch(8'd0);
            vq.push_back(mk(1'b0, OP_NOP, 1'b1, 4'd10, SB_NONE, 8'd1, 3'b000));
            for (int k = 0; k < 3; k++)
                vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd10, SB_NONE, 8'd1, 3'b000));
            v = mk(1'b0, OP_X, 1'b1, 4'd1, SB_FA, 8'd1, 3'b000);
            v.stp = 1'b1;
            vq.push_back(v);
            push_fetch(8'd1);
            vq.push_back(mk(1'b0, OP_NOP, 1'b1, 4'd10, SB_NONE, 8'd2, 3'b000));
            vq.push_back(mk(1'b0, OP_X, 1'b1, 4'd10, SB_NONE, 8'd2, 3'b000));
            apply("step");
            step_mode = 1'b0;
            @(posedge clk);
            #1;
            chk("step_mode0 exit state", 32'(state), 32'd1);
            chk("step_mode0 exit count", 32'(instr_count), 32'd2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
